// File: rtl/mips32_mem_arbiter.sv
// mips32_mem_arbiter
// ------------------
// Single-port memory arbiter for the pipelined MIPS32 core. One unified
// instruction/data memory is shared between the program loader/debug port
// (ld_*), the MEM-stage data port (d_*) and the IF-stage fetch port (i_*).
// The arbiter also drives cpu_hold to stall the pipeline when a CPU request
// is denied or while the loader owns memory.
//
// Optional feature macro: MIPS32_ARB_STARVE_GUARD_EN
//   defined   : fetch starvation counter and fetch promotion are active
//   undefined : fixed priority loader > data > fetch, starve_cnt_o tied to 0
//
// Ports:
//   clk1, rst_n                   clock (rising edge), async active-low reset
//   ld_req/ld_we/ld_addr/ld_wdata loader request; ld_gnt, ld_rvalid
//   d_req/d_we/d_addr/d_wdata     data port request; d_gnt, d_rvalid
//   i_req/i_addr                  fetch request; i_gnt, i_rvalid
//   rdata                         shared read data, qualified by *_rvalid
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory array interface
//   cpu_hold                      pipeline stall request
//   starve_cnt_o                  current fetch starvation count
module mips32_mem_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          cpu_hold,
    output logic [3:0]    starve_cnt_o
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LOAD = 2'd1,
        EXIT = 2'd2
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_LD   = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;
    localparam logic [1:0] OWN_I    = 2'd3;

    // The promotion threshold must fit the 4-bit saturating counter.
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("mips32_mem_arbiter: STARVE_MAX must be in 1..15");
    end

    state_t     state;
    state_t     state_nxt;
    logic [1:0] owner;
    logic       promote;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Grants are purely combinational so an uncontested request is served in
    // the same cycle. The loader entry cycle is still RUN, but ld_req wins it,
    // so the CPU request arriving alongside the first ld_req is denied.
    always_comb begin
        state_nxt = state;
        ld_gnt    = 1'b0;
        d_gnt     = 1'b0;
        i_gnt     = 1'b0;
        case (state)
            RUN: begin
                if (ld_req) begin
                    ld_gnt    = 1'b1;
                    state_nxt = LOAD;
                end else if (d_req && i_req && promote) begin
                    i_gnt = 1'b1;
                end else if (d_req) begin
                    d_gnt = 1'b1;
                end else if (i_req) begin
                    i_gnt = 1'b1;
                end
            end
            LOAD: begin
                if (ld_req) begin
                    ld_gnt = 1'b1;
                end else begin
                    state_nxt = EXIT;
                end
            end
            // Quiet cycle: lets the last loader rvalid drain before any CPU grant.
            EXIT: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (ld_gnt) begin
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
            mem_we    = ld_we;
        end else if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_we    = d_we;
        end else if (i_gnt) begin
            mem_addr  = i_addr;
        end
    end

    assign mem_en = ld_gnt | d_gnt | i_gnt;

    // Owner tag of the read issued this cycle; its data returns next cycle.
    // Reset clears it asynchronously so a pending rvalid vanishes at once.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            owner <= OWN_NONE;
        end else if (ld_gnt && !ld_we) begin
            owner <= OWN_LD;
        end else if (d_gnt && !d_we) begin
            owner <= OWN_D;
        end else if (i_gnt) begin
            owner <= OWN_I;
        end else begin
            owner <= OWN_NONE;
        end
    end

    assign ld_rvalid = (owner == OWN_LD);
    assign d_rvalid  = (owner == OWN_D);
    assign i_rvalid  = (owner == OWN_I);
    assign rdata     = mem_rdata;

    assign cpu_hold = ld_req | (state != RUN) | (d_req & ~d_gnt) | (i_req & ~i_gnt);

`ifdef MIPS32_ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_TH = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;
    logic       promote_q;

    // Promotion is registered from the registered count, so fetch wins the
    // cycle after the count has reached the threshold.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
            promote_q  <= 1'b0;
        end else if (i_req && !i_gnt) begin
            if (starve_cnt != 4'd15) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
            promote_q <= (starve_cnt >= STARVE_TH);
        end else begin
            starve_cnt <= 4'd0;
            promote_q  <= 1'b0;
        end
    end

    assign promote      = promote_q;
    assign starve_cnt_o = starve_cnt;
`else
    assign promote      = 1'b0;
    assign starve_cnt_o = 4'd0;
`endif

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// tb_mips32_mem_arbiter
// ---------------------
// Testbench for mips32_mem_arbiter: table-driven vectors covering loading,
// readback, EXIT quiet cycle, write-then-fetch and loader entry, followed by
// hand-written sequences for fetch starvation and reset during a read.
// Works with and without MIPS32_ARB_STARVE_GUARD_EN.
module tb_mips32_mem_arbiter;

    logic        clk1;
    logic        rst_n;
    logic        ld_req, ld_we;
    logic [9:0]  ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_gnt, ld_rvalid;
    logic        d_req, d_we;
    logic [9:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt, d_rvalid;
    logic        i_req;
    logic [9:0]  i_addr;
    logic        i_gnt, i_rvalid;
    logic [31:0] rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        cpu_hold;
    logic [3:0]  starve_cnt_o;

    int check_count = 0;
    int pass_count  = 0;

    mips32_mem_arbiter #(
        .AW(10),
        .DW(32),
        .STARVE_MAX(4)
    ) dut (
        .clk1(clk1), .rst_n(rst_n),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_hold(cpu_hold), .starve_cnt_o(starve_cnt_o)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Synchronous single-port memory: read data appears the cycle after a read.
    logic [31:0] mem_model [0:1023];
    initial begin
        for (int a = 0; a < 1024; a++) mem_model[a] = 32'd0;
        mem_rdata = 32'd0;
    end
    always @(posedge clk1) begin
        if (mem_en) begin
            if (mem_we) mem_model[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_model[mem_addr];
        end
    end

    // Factorial program image loaded at Mem[0..10].
    logic [31:0] prog [0:10];
    initial begin
        prog[0]  = 32'h8C01_00C8;
        prog[1]  = 32'h2002_0001;
        prog[2]  = 32'h7041_1002;
        prog[3]  = 32'h2021_FFFF;
        prog[4]  = 32'h1420_FFFD;
        prog[5]  = 32'h0000_0000;
        prog[6]  = 32'hAC02_00C6;
        prog[7]  = 32'h0000_0000;
        prog[8]  = 32'h0000_0000;
        prog[9]  = 32'h1000_FFFF;
        prog[10] = 32'h0000_0000;
    end

    typedef struct {
        logic        ld_req, ld_we;
        logic [9:0]  ld_addr;
        logic [31:0] ld_wdata;
        logic        d_req, d_we;
        logic [9:0]  d_addr;
        logic [31:0] d_wdata;
        logic        i_req;
        logic [9:0]  i_addr;
        logic        exp_ld_gnt, exp_d_gnt, exp_i_gnt;
        logic        exp_ld_rvalid, exp_d_rvalid, exp_i_rvalid;
        logic        exp_hold;
        logic        chk_rdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t idle_vec();
        vec_t v;
        v.ld_req = 0; v.ld_we = 0; v.ld_addr = '0; v.ld_wdata = '0;
        v.d_req = 0; v.d_we = 0; v.d_addr = '0; v.d_wdata = '0;
        v.i_req = 0; v.i_addr = '0;
        v.exp_ld_gnt = 0; v.exp_d_gnt = 0; v.exp_i_gnt = 0;
        v.exp_ld_rvalid = 0; v.exp_d_rvalid = 0; v.exp_i_rvalid = 0;
        v.exp_hold = 0; v.chk_rdata = 0; v.exp_rdata = '0;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        ld_req = v.ld_req; ld_we = v.ld_we; ld_addr = v.ld_addr; ld_wdata = v.ld_wdata;
        d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
        i_req = v.i_req; i_addr = v.i_addr;
    endtask

    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        logic        exp_en, exp_we;
        logic [9:0]  exp_addr;
        logic [31:0] exp_wdata;
        logic        starve_on;

`ifdef MIPS32_ARB_STARVE_GUARD_EN
        starve_on = 1'b1;
`else
        starve_on = 1'b0;
`endif

        // ---------------- vector table ----------------
        // V0: idle, right after reset release
        v = idle_vec(); vecs.push_back(v);
        // V1..V11: loader writes program; fetch (and data on entry) denied and held
        for (int a = 0; a <= 10; a++) begin
            v = idle_vec();
            v.ld_req = 1; v.ld_we = 1; v.ld_addr = 10'(a); v.ld_wdata = prog[a];
            v.i_req = 1; v.i_addr = 10'd2;
            v.d_req = (a == 0); v.d_addr = 10'd3;
            v.exp_ld_gnt = 1; v.exp_hold = 1;
            vecs.push_back(v);
        end
        // V12: Mem[200] = 8
        v = idle_vec(); v.ld_req = 1; v.ld_we = 1; v.ld_addr = 10'd200; v.ld_wdata = 32'd8;
        v.i_req = 1; v.i_addr = 10'd2; v.exp_ld_gnt = 1; v.exp_hold = 1; vecs.push_back(v);
        // V13: loader readback of Mem[200]
        v = idle_vec(); v.ld_req = 1; v.ld_addr = 10'd200;
        v.i_req = 1; v.i_addr = 10'd2; v.exp_ld_gnt = 1; v.exp_hold = 1; vecs.push_back(v);
        // V14: ld_req drops (still LOAD): readback returns 8
        v = idle_vec(); v.i_req = 1; v.i_addr = 10'd2;
        v.exp_ld_rvalid = 1; v.chk_rdata = 1; v.exp_rdata = 32'd8; v.exp_hold = 1; vecs.push_back(v);
        // V15: EXIT quiet cycle
        v = idle_vec(); v.i_req = 1; v.i_addr = 10'd2; v.exp_hold = 1; vecs.push_back(v);
        // V16: back in RUN, fetch granted
        v = idle_vec(); v.i_req = 1; v.i_addr = 10'd2; v.exp_i_gnt = 1; vecs.push_back(v);
        // V17: SW 40320 -> 198 with fetch of 198 in the same cycle
        v = idle_vec(); v.d_req = 1; v.d_we = 1; v.d_addr = 10'd198; v.d_wdata = 32'd40320;
        v.i_req = 1; v.i_addr = 10'd198; v.exp_d_gnt = 1; v.exp_hold = 1;
        v.exp_i_rvalid = 1; v.chk_rdata = 1; v.exp_rdata = prog[2]; vecs.push_back(v);
        // V18: fetch of 198 granted
        v = idle_vec(); v.i_req = 1; v.i_addr = 10'd198; v.exp_i_gnt = 1; vecs.push_back(v);
        // V19: fetch returns the new value
        v = idle_vec(); v.exp_i_rvalid = 1; v.chk_rdata = 1; v.exp_rdata = 32'd40320; vecs.push_back(v);
        // V20..V23: back-to-back mixed reads
        v = idle_vec(); v.d_req = 1; v.d_addr = 10'd200; v.exp_d_gnt = 1; vecs.push_back(v);
        v = idle_vec(); v.d_req = 1; v.d_addr = 10'd198; v.i_req = 1; v.i_addr = 10'd0;
        v.exp_d_gnt = 1; v.exp_hold = 1; v.exp_d_rvalid = 1; v.chk_rdata = 1; v.exp_rdata = 32'd8;
        vecs.push_back(v);
        v = idle_vec(); v.i_req = 1; v.i_addr = 10'd0; v.exp_i_gnt = 1;
        v.exp_d_rvalid = 1; v.chk_rdata = 1; v.exp_rdata = 32'd40320; vecs.push_back(v);
        v = idle_vec(); v.exp_i_rvalid = 1; v.chk_rdata = 1; v.exp_rdata = prog[0]; vecs.push_back(v);
        // V24: fetch read of Mem[1]
        v = idle_vec(); v.i_req = 1; v.i_addr = 10'd1; v.exp_i_gnt = 1; vecs.push_back(v);
        // V25: loader entry; previous fetch still returns
        v = idle_vec(); v.ld_req = 1; v.ld_addr = 10'd0; v.i_req = 1; v.i_addr = 10'd2;
        v.d_req = 1; v.d_addr = 10'd200; v.exp_ld_gnt = 1; v.exp_hold = 1;
        v.exp_i_rvalid = 1; v.chk_rdata = 1; v.exp_rdata = prog[1]; vecs.push_back(v);
        // V26: loader write while its read returns
        v = idle_vec(); v.ld_req = 1; v.ld_we = 1; v.ld_addr = 10'd300; v.ld_wdata = 32'd5;
        v.i_req = 1; v.i_addr = 10'd2; v.d_req = 1; v.d_addr = 10'd200;
        v.exp_ld_gnt = 1; v.exp_hold = 1;
        v.exp_ld_rvalid = 1; v.chk_rdata = 1; v.exp_rdata = prog[0]; vecs.push_back(v);
        // V27: ld_req drops (LOAD), V28: EXIT
        v = idle_vec(); v.i_req = 1; v.i_addr = 10'd2; v.d_req = 1; v.d_addr = 10'd200;
        v.exp_hold = 1; vecs.push_back(v);
        vecs.push_back(v);
        // V29: RUN, data beats fetch (no promotion yet in either build)
        v = idle_vec(); v.i_req = 1; v.i_addr = 10'd2; v.d_req = 1; v.d_addr = 10'd200;
        v.exp_d_gnt = 1; v.exp_hold = 1; vecs.push_back(v);
        // V30: idle, data read returns
        v = idle_vec(); v.exp_d_rvalid = 1; v.chk_rdata = 1; v.exp_rdata = 32'd8; vecs.push_back(v);

        // ---------------- reset with requests held ----------------
        v = idle_vec(); applyStimulus(v);
        rst_n = 1'b0;
        d_req = 1; d_we = 1; d_addr = 10'd5; i_req = 1; i_addr = 10'd6;
        repeat (2) @(posedge clk1);
        #4;
        checkOutput("reset_d_gnt", 0, 32'(d_gnt), 32'd1);
        checkOutput("reset_i_gnt", 0, 32'(i_gnt), 32'd0);
        checkOutput("reset_rvalid", 0, {29'd0, ld_rvalid, d_rvalid, i_rvalid}, 32'd0);
        checkOutput("reset_starve_cnt", 0, 32'(starve_cnt_o), 32'd0);
        @(posedge clk1); #2 rst_n = 1'b1;
        #2;
        checkOutput("release_d_gnt", 0, 32'(d_gnt), 32'd1);
        checkOutput("release_i_gnt", 0, 32'(i_gnt), 32'd0);
        checkOutput("release_rvalid", 0, {29'd0, ld_rvalid, d_rvalid, i_rvalid}, 32'd0);

        // ---------------- table loop ----------------
        for (int k = 0; k < vecs.size(); k++) begin
            @(posedge clk1); #2;
            applyStimulus(vecs[k]);
            #2;
            v = vecs[k];
            checkOutput("ld_gnt", k, 32'(ld_gnt), 32'(v.exp_ld_gnt));
            checkOutput("d_gnt", k, 32'(d_gnt), 32'(v.exp_d_gnt));
            checkOutput("i_gnt", k, 32'(i_gnt), 32'(v.exp_i_gnt));
            checkOutput("ld_rvalid", k, 32'(ld_rvalid), 32'(v.exp_ld_rvalid));
            checkOutput("d_rvalid", k, 32'(d_rvalid), 32'(v.exp_d_rvalid));
            checkOutput("i_rvalid", k, 32'(i_rvalid), 32'(v.exp_i_rvalid));
            checkOutput("cpu_hold", k, 32'(cpu_hold), 32'(v.exp_hold));
            if (v.chk_rdata) checkOutput("rdata", k, rdata, v.exp_rdata);
            exp_en = v.exp_ld_gnt | v.exp_d_gnt | v.exp_i_gnt;
            exp_addr = '0; exp_we = 1'b0; exp_wdata = '0;
            if (v.exp_ld_gnt) begin
                exp_addr = v.ld_addr; exp_we = v.ld_we; exp_wdata = v.ld_wdata;
            end else if (v.exp_d_gnt) begin
                exp_addr = v.d_addr; exp_we = v.d_we; exp_wdata = v.d_wdata;
            end else if (v.exp_i_gnt) begin
                exp_addr = v.i_addr;
            end
            checkOutput("mem_en", k, 32'(mem_en), 32'(exp_en));
            if (exp_en) begin
                checkOutput("mem_addr", k, 32'(mem_addr), 32'(exp_addr));
                checkOutput("mem_we", k, 32'(mem_we), 32'(exp_we));
                if (exp_we) checkOutput("mem_wdata", k, mem_wdata, exp_wdata);
            end
        end

        // ---------------- fetch starvation ----------------
        for (int c = 1; c <= 12; c++) begin
            logic exp_i;
            @(posedge clk1); #2;
            v = idle_vec();
            v.d_req = 1; v.d_addr = 10'd7; v.i_req = 1; v.i_addr = 10'd8;
            applyStimulus(v);
            #2;
            exp_i = starve_on && ((c % 6) == 0);
            checkOutput("starve_i_gnt", c, 32'(i_gnt), 32'(exp_i));
            checkOutput("starve_d_gnt", c, 32'(d_gnt), 32'(!exp_i));
            checkOutput("starve_hold", c, 32'(cpu_hold), 32'd1);
            checkOutput("starve_cnt", c, 32'(starve_cnt_o), starve_on ? 32'((c - 1) % 6) : 32'd0);
        end
        @(posedge clk1); #2 applyStimulus(idle_vec());

        // ---------------- reset the cycle after a data read grant ----------------
        @(posedge clk1); #2;
        v = idle_vec(); v.d_req = 1; v.d_addr = 10'd200; applyStimulus(v);
        #2 checkOutput("rst_mid_d_gnt", 0, 32'(d_gnt), 32'd1);
        @(posedge clk1); #2;
        applyStimulus(idle_vec());
        rst_n = 1'b0;
        #2;
        checkOutput("rst_mid_d_rvalid", 0, 32'(d_rvalid), 32'd0);
        checkOutput("rst_mid_hold", 0, 32'(cpu_hold), 32'd0);
        @(posedge clk1); #2 rst_n = 1'b1;
        #2 checkOutput("rst_after_rvalid", 0, {29'd0, ld_rvalid, d_rvalid, i_rvalid}, 32'd0);

        // ---------------- reset while in LOAD returns to RUN ----------------
        @(posedge clk1); #2;
        v = idle_vec(); v.ld_req = 1; v.ld_we = 1; v.ld_addr = 10'd300; v.ld_wdata = 32'd5;
        applyStimulus(v);
        #2 checkOutput("rst_load_ld_gnt", 0, 32'(ld_gnt), 32'd1);
        @(posedge clk1); #2;
        applyStimulus(idle_vec());
        #2 checkOutput("rst_load_hold_before", 0, 32'(cpu_hold), 32'd1);
        #2 rst_n = 1'b0;
        d_req = 1; d_we = 0; d_addr = 10'd200;
        #2;
        checkOutput("rst_load_hold_after", 0, 32'(cpu_hold), 32'd0);
        checkOutput("rst_load_d_gnt", 0, 32'(d_gnt), 32'd1);
        @(posedge clk1); #2;
        rst_n = 1'b1; d_req = 0;
        #2 checkOutput("rst_load_d_rvalid", 0, 32'(d_rvalid), 32'd0);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/mips32_mem_arbiter.md
# mips32_mem_arbiter

Single-port memory arbiter for the pipelined MIPS32 core. It shares one unified instruction/data memory between three requesters:
- the external program loader/debug port;
- the MEM-stage data port (LW/SW);
- the IF-stage instruction fetch port.

It also tells the core when to stall. The arbiter sits between the core's memory-stage logic and the memory array, replacing direct array access by the pipeline.

## Interface
Parameters:
- AW, 10, word-address width
- DW, 32, data width
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch is promoted (range 1–15)

Ports:
- clk1  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ld_req / ld_we  in  1 / 1  loader request / write
- ld_addr / ld_wdata  in  AW / DW  loader address / write data
- ld_gnt  out  1  loader granted this cycle
- ld_rvalid  out  1  loader read data valid
- d_req / d_we  in  1 / 1  data request / write
- d_addr / d_wdata  in  AW / DW  data address / write data
- d_gnt / d_rvalid  out  1 / 1  data grant / read data valid
- i_req  in  1  fetch request
- i_addr  in  AW  fetch address
- i_gnt / i_rvalid  out  1 / 1  fetch grant / read data valid
- rdata  out  DW  read data, common to all requesters, qualified by the *_rvalid strobes
- mem_en / mem_we  out  1 / 1  memory access / write enable
- mem_addr / mem_wdata  out  AW / DW  memory address / write data
- mem_rdata  in  DW  memory read data, valid the cycle after a read
- cpu_hold  out  1  stall request to the pipeline
- starve_cnt_o  out  4  current fetch starvation count

## Operation
States:
- RUN: normal arbitration.
- LOAD: the loader owns memory; no CPU grants.
- EXIT: one quiet cycle after loading ends; no grants.

Transitions:
- RUN→LOAD when ld_req=1.
- LOAD→EXIT when ld_req=0.
- EXIT→RUN unconditionally.
- LOAD→LOAD while ld_req=1.

Grant selection:
- Grants are combinational from the current state and requests. At most one grant per cycle.
- The granted requester's addr, we and wdata drive mem_*. mem_en equals the OR of all grants.
- Priority in RUN and LOAD: loader > data > fetch.
- Exception: data and fetch both request, fetch is promoted, and ld_req=0. Then fetch wins.
- In EXIT, all grants are 0.

Read return:
- A granted read (we=0) registers a 2-bit owner tag.
- The next cycle, the matching *_rvalid is 1 and rdata=mem_rdata.
- Writes produce no rvalid.

cpu_hold:
- cpu_hold = ld_req | (state≠RUN) | (d_req & ~d_gnt) | (i_req & ~i_gnt).
- The pipeline freezes the stage whose request was denied and keeps its request stable until granted.

Starvation counter:
- Increments on each cycle with i_req=1 & i_gnt=0, saturating at 15.
- Clears on i_gnt=1 or i_req=0.
- Fetch is promoted when the counter ≥ STARVE_MAX.

## Timing
- Reset: state=RUN, owner tag=none, all *_rvalid=0, starve counter=0. Grants and mem_en follow the request inputs combinationally.
- Asserting rst_n=0 mid-read drops the pending rvalid immediately. No rvalid appears after reset release.
- Request-to-grant: same cycle when uncontested. Read latency: grant cycle + 1.
- Back-to-back reads by any mix of requesters: one per cycle. rvalid pulses are never lost or reordered.
- Loader entry: the CPU request in the same cycle as the first ld_req is denied and held. A read granted in the previous cycle still returns its rvalid in the first LOAD cycle.
- EXIT guarantees that no loader rvalid overlaps the first CPU grant.
- Simultaneous data write and fetch to the same address: the data write is granted first. The fetch then reads the new value the following cycle.
- The counter update and promotion decision both use the registered count. A promotion therefore takes effect the cycle after the threshold is reached.

## Configuration
- MIPS32_ARB_STARVE_GUARD_EN defined: the starvation counter and fetch promotion are active as described.
- Not defined: fixed priority loader > data > fetch, with no promotion. starve_cnt_o is tied to 0, and the counter logic is absent.

## Test plan
- Reset with d_req=1 and i_req=1 held, then release: d_gnt=1 and i_gnt=0 in the first cycle. No *_rvalid during or right after reset.
- Loader writes Mem[0..10] with the factorial program and Mem[200]=8, then drops ld_req:
  - cpu_hold=1 for all load cycles plus EXIT;
  - no d_gnt/i_gnt until EXIT→RUN;
  - loader readback of Mem[200] gives ld_rvalid=1 with rdata=8 one cycle after grant.
- d_req=1 continuously with i_req=1, STARVE_MAX=4, macro defined: i_gnt=1 in the 6th cycle, the counter clears, then the pattern repeats. Without the macro, i_gnt stays 0 and cpu_hold stays 1.
- Same cycle, data SW to address 198 with data 40320 and fetch from address 198: the write is granted, fetch is granted next cycle, and i_rvalid with rdata=40320 follows.
- Assert rst_n=0 the cycle after a data read grant: d_rvalid stays 0 and the state returns to RUN.
- ld_req rises in the same cycle as a fetch read grant from the previous cycle: i_rvalid returns in the first LOAD cycle, and no CPU grant occurs while ld_req=1.
